// File: rtl/pwm_level_recover_if.sv
// Bundles the measured PWM line and the recovered-level outputs of pwm_level_recover.
// The master drives the line; the slave (the recovery block) returns the level report.
interface pwm_level_recover_if #(
  parameter int unsigned LEVEL_BITS = 8
) ();
  logic                  pwm_in;
  logic [LEVEL_BITS-1:0] level;
  logic                  level_valid;
  logic                  rise;
  logic                  dark;

  modport master (
    output pwm_in,
    input  level,
    input  level_valid,
    input  rise,
    input  dark
  );

  modport slave (
    input  pwm_in,
    output level,
    output level_valid,
    output rise,
    output dark
  );
endinterface

// File: rtl/pwm_level_recover.sv
// Recovers the duty level of an asynchronous PWM line over fixed 2**LEVEL_BITS-cycle windows.
// It also flags upward level jumps (fade restarts) and sustained dark periods.
module pwm_level_recover #(
  parameter int unsigned LEVEL_BITS   = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned RISE_MIN     = 16,
  parameter int unsigned DARK_WINDOWS = 4
) (
  input logic               clk,
  input logic               reset,
  pwm_level_recover_if.slave bus
);

  localparam int unsigned CntW = LEVEL_BITS + 1;
  localparam logic [LEVEL_BITS-1:0] WinLast  = '1;
  localparam logic [LEVEL_BITS-1:0] LevelMax = '1;
  localparam logic [CntW-1:0]       RiseMin  = CntW'(RISE_MIN);
  localparam logic [7:0]            DarkMax  = 8'(DARK_WINDOWS);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [LEVEL_BITS-1:0]  win_cnt_q, win_cnt_d;
  logic [CntW-1:0]        hi_cnt_q, hi_cnt_d;
  logic [LEVEL_BITS-1:0]  level_q, level_d;
  logic                   level_valid_q, level_valid_d;
  logic                   rise_q, rise_d;
  logic                   dark_q, dark_d;
  logic                   have_prev_q, have_prev_d;
  logic [LEVEL_BITS-1:0]  prev_level_q, prev_level_d;
  logic [7:0]             dark_cnt_q, dark_cnt_d;

  logic                  s;
  logic                  win_end;
  logic [CntW-1:0]       total;
  logic [LEVEL_BITS-1:0] new_level;
  logic                  rise_hit;

  assign s        = sync_q[SYNC_STAGES-1];
  assign win_end  = (win_cnt_q == WinLast);
  assign total    = hi_cnt_q + CntW'(s);
  // A window that was high on every cycle counts one past the level range.
  assign new_level = total[LEVEL_BITS] ? LevelMax : total[LEVEL_BITS-1:0];
  assign rise_hit  = have_prev_q &&
                     ({1'b0, new_level} >= ({1'b0, prev_level_q} + RiseMin));

  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
    win_cnt_d     = win_cnt_q + 1'b1;
    hi_cnt_d      = total;
    level_d       = level_q;
    level_valid_d = 1'b0;
    rise_d        = 1'b0;
    dark_d        = dark_q;
    have_prev_d   = have_prev_q;
    prev_level_d  = prev_level_q;
    dark_cnt_d    = dark_cnt_q;

    if (win_end) begin
      hi_cnt_d      = '0;
      level_d       = new_level;
      level_valid_d = 1'b1;
      rise_d        = rise_hit;
      have_prev_d   = 1'b1;
      prev_level_d  = new_level;
      if (new_level == '0) begin
        dark_cnt_d = (dark_cnt_q == DarkMax) ? dark_cnt_q : dark_cnt_q + 8'd1;
      end else begin
        dark_cnt_d = 8'd0;
      end
      dark_d = (dark_cnt_d == DarkMax);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q        <= '0;
      win_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
      rise_q        <= 1'b0;
      dark_q        <= 1'b0;
      have_prev_q   <= 1'b0;
      prev_level_q  <= '0;
      dark_cnt_q    <= 8'd0;
    end else begin
      sync_q        <= sync_d;
      win_cnt_q     <= win_cnt_d;
      hi_cnt_q      <= hi_cnt_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
      rise_q        <= rise_d;
      dark_q        <= dark_d;
      have_prev_q   <= have_prev_d;
      prev_level_q  <= prev_level_d;
      dark_cnt_q    <= dark_cnt_d;
    end
  end

  assign bus.level       = level_q;
  assign bus.level_valid = level_valid_q;
  assign bus.rise        = rise_q;
  assign bus.dark        = dark_q;

endmodule
